mac_sequencer: RTL and testbench

Controller that sequences one external mac_core through a full dense layer: for each of NEURONS output neurons it streams WIDTH pixel/weight pairs from synchronous-read memories into the MAC, one pair per cycle. It seeds the accumulator per neuron, freezes the MAC between neurons, and emits each finished dot product on a valid/ready result stream. It sits between the pixel/weight RAMs and the classifier output logic.

---
 rtl/mac_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mac_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Dense-layer MAC sequencer: streams pixel/weight pairs per neuron into an
// external mac_core. Optional argmax tracking under MAC_SEQ_ARGMAX_EN.
module mac_sequencer #(
  parameter int BITS    = 24,
  parameter int WIDTH   = 784,
  parameter int NEURONS = 10,
  parameter int PA_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int WA_W    = (WIDTH * NEURONS > 1) ? $clog2(WIDTH * NEURONS) : 1,
  parameter int NI_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [PA_W-1:0]     pix_addr_o,
  input  logic [BITS-1:0]     pix_data_i,
  output logic [WA_W-1:0]     w_addr_o,
  input  logic [BITS-1:0]     w_data_i,
  output logic [BITS-1:0]     mac_pic_o,
  output logic [BITS-1:0]     mac_w_o,
  output logic [2*BITS-1:0]   mac_acc_prev_o,
  input  logic [2*BITS-1:0]   mac_acc_i,
`ifdef MAC_SEQ_ARGMAX_EN
  output logic [NI_W-1:0]     class_o,
  output logic                class_valid_o,
`endif
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [2*BITS-1:0]   res_data_o,
  output logic [NI_W-1:0]     res_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [PA_W-1:0] P_LAST = PA_W'(WIDTH - 1);
  localparam logic [NI_W-1:0] N_LAST = NI_W'(NEURONS - 1);

  state_t              r_state;
  logic [PA_W-1:0]     r_p;
  logic [WA_W-1:0]     r_wa;
  logic [NI_W-1:0]     r_n;
  logic                r_drain;
  logic                r_opv;
  logic                r_opfirst;
  logic                r_res_valid;
  logic [2*BITS-1:0]   r_res_data;
  logic [NI_W-1:0]     r_res_idx;
  logic                r_done;
  logic                r_busy;
  logic                w_accept;

  assign w_accept = r_res_valid & res_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_wa        <= '0;
      r_n         <= '0;
      r_drain     <= 1'b0;
      r_opv       <= 1'b0;
      r_opfirst   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // operand for the address issued this cycle arrives next cycle
      r_opv     <= (r_state == S_RUN);
      r_opfirst <= (r_state == S_RUN) && (r_p == '0);
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_p     <= '0;
            r_wa    <= '0;
            r_n     <= '0;
          end
        end
        S_RUN: begin
          if (r_p == P_LAST) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_p  <= r_p + 1'b1;
            r_wa <= r_wa + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!r_drain) begin
            r_drain <= 1'b1;
          end else begin
            r_res_data  <= mac_acc_i;
            r_res_idx   <= r_n;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (w_accept) begin
            r_res_valid <= 1'b0;
            if (r_n == N_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_n     <= r_n + 1'b1;
              r_p     <= '0;
              r_wa    <= r_wa + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pix_addr_o  = r_p;
  assign w_addr_o    = r_wa;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_idx_o   = r_res_idx;

  // without a valid operand the MAC is fed its own value and holds
  assign mac_pic_o      = r_opv ? pix_data_i : '0;
  assign mac_w_o        = r_opv ? w_data_i : '0;
  assign mac_acc_prev_o = (r_opv && r_opfirst) ? '0 : mac_acc_i;

`ifdef MAC_SEQ_ARGMAX_EN
  logic [2*BITS-1:0] r_max;
  logic [NI_W-1:0]   r_best;
  logic [NI_W-1:0]   r_class;
  logic              r_class_valid;
  logic              w_take;
  logic [NI_W-1:0]   w_best;

  // strict compare: ties keep the lower index
  assign w_take = (r_n == '0) ||
                  ($signed(r_res_data) > $signed(r_max));
  assign w_best = w_take ? r_n : r_best;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max         <= '0;
      r_best        <= '0;
      r_class       <= '0;
      r_class_valid <= 1'b0;
    end else begin
      r_class_valid <= 1'b0;
      if (r_state == S_IDLE && start_i) begin
        r_class <= '0;
      end
      if (r_state == S_OUT && w_accept) begin
        if (w_take) begin
          r_max  <= r_res_data;
          r_best <= r_n;
        end
        if (r_n == N_LAST) begin
          r_class       <= w_best;
          r_class_valid <= 1'b1;
        end
      end
    end
  end

  assign class_o       = r_class;
  assign class_valid_o = r_class_valid;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with behavioural RAMs and mac_core.
// BITS=8, WIDTH=4, NEURONS=3.
module tb_mac_sequencer;

  localparam int BITS    = 8;
  localparam int WIDTH   = 4;
  localparam int NEURONS = 3;
  localparam int PA_W    = 2;
  localparam int WA_W    = 4;
  localparam int NI_W    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_i;
  logic              busy_o;
  logic              done_o;
  logic [PA_W-1:0]   pix_addr_o;
  logic [BITS-1:0]   pix_data_i;
  logic [WA_W-1:0]   w_addr_o;
  logic [BITS-1:0]   w_data_i;
  logic [BITS-1:0]   mac_pic_o;
  logic [BITS-1:0]   mac_w_o;
  logic [2*BITS-1:0] mac_acc_prev_o;
  logic [2*BITS-1:0] mac_acc_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [2*BITS-1:0] res_data_o;
  logic [NI_W-1:0]   res_idx_o;
`ifdef MAC_SEQ_ARGMAX_EN
  logic [NI_W-1:0]   class_o;
  logic              class_valid_o;
`endif

  always #5 clk = ~clk;

  mac_sequencer #(
    .BITS(BITS), .WIDTH(WIDTH), .NEURONS(NEURONS),
    .PA_W(PA_W), .WA_W(WA_W), .NI_W(NI_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .pix_addr_o(pix_addr_o),
    .pix_data_i(pix_data_i),
    .w_addr_o(w_addr_o),
    .w_data_i(w_data_i),
    .mac_pic_o(mac_pic_o),
    .mac_w_o(mac_w_o),
    .mac_acc_prev_o(mac_acc_prev_o),
    .mac_acc_i(mac_acc_i),
`ifdef MAC_SEQ_ARGMAX_EN
    .class_o(class_o),
    .class_valid_o(class_valid_o),
`endif
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o(res_data_o),
    .res_idx_o(res_idx_o)
  );

  // synchronous-read RAMs
  logic [BITS-1:0] pix_mem [0:3];
  logic [BITS-1:0] w_mem   [0:15];
  always @(posedge clk) begin
    pix_data_i <= pix_mem[pix_addr_o];
    w_data_i   <= w_mem[w_addr_o];
  end

  // mac_core model: acc <= acc_prev + pic*w, wrapping in 16 bits
  logic [15:0] pe, we, prod;
  assign pe   = {{8{mac_pic_o[7]}}, mac_pic_o};
  assign we   = {{8{mac_w_o[7]}}, mac_w_o};
  assign prod = pe * we;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mac_acc_i <= '0;
    else       mac_acc_i <= mac_acc_prev_o + prod;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] r_data [0:7];
  int r_idx [0:7];
  int r_cyc [0:7];
  int n_res;
  int n_done;
  int done_cyc;
  int cls_seen;
  int cls_cyc;

  task automatic load_std();
    for (int i = 0; i < 4; i++) begin
      pix_mem[i]   = 8'(i + 1);
      w_mem[i]     = 8'(1);
      w_mem[4 + i] = 8'(-1);
      w_mem[8 + i] = 8'(2);
    end
  endtask

  task automatic run_layer(input int stall_idx, input int stall_len,
                           input int stall_exp, input int pulse_cyc);
    int stalled;
    bit fin;
    stalled  = 0;
    fin      = 1'b0;
    n_res    = 0;
    n_done   = 0;
    done_cyc = -1;
    cls_seen = -1;
    cls_cyc  = -1;
    @(posedge clk); #1;
    start_i     = 1'b1;
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 0; c < 150 && !fin; c++) begin
      start_i     = (c == pulse_cyc);
      res_ready_i = 1'b1;
      if (res_valid_o && int'(res_idx_o) == stall_idx &&
          stalled < stall_len) begin
        res_ready_i = 1'b0;
        stalled++;
        n_checks++;
        if (res_data_o !== 16'(stall_exp)) begin
          n_fail++;
          $display("FAIL stall_data c=%0d: got %0d want %0d",
                   c, $signed(res_data_o), stall_exp);
        end
        n_checks++;
        if (mac_acc_i !== 16'(stall_exp)) begin
          n_fail++;
          $display("FAIL stall_mac_acc c=%0d: got %0d want %0d",
                   c, $signed(mac_acc_i), stall_exp);
        end
      end
      if (res_valid_o && res_ready_i && n_res < 8) begin
        r_data[n_res] = res_data_o;
        r_idx[n_res]  = int'(res_idx_o);
        r_cyc[n_res]  = c;
        n_res++;
      end
      if (done_o) begin
        n_done++;
        done_cyc = c;
      end
`ifdef MAC_SEQ_ARGMAX_EN
      if (class_valid_o) begin
        cls_seen = int'(class_o);
        cls_cyc  = c;
      end
`endif
      if (done_cyc >= 0 && c >= done_cyc + 3) fin = 1'b1;
      @(posedge clk); #1;
    end
    start_i     = 1'b0;
    res_ready_i = 1'b1;
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL layer_timeout: got done=%0d want done", n_done);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    start_i     = 1'b0;
    res_ready_i = 1'b1;
    load_std();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_o, done_o, res_valid_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {busy_o, done_o, res_valid_o});
    end
    n_checks++;
    if (res_data_o !== 16'd0 || res_idx_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_res: got %0d/%0d want 0/0",
               res_data_o, res_idx_o);
    end
    n_checks++;
    if (pix_addr_o !== 2'd0 || w_addr_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d/%0d want 0/0",
               pix_addr_o, w_addr_o);
    end
    n_checks++;
    if (mac_pic_o !== 8'd0 || mac_w_o !== 8'd0 ||
        mac_acc_prev_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mac: got %0d/%0d/%0d want 0/0/0",
               mac_pic_o, mac_w_o, mac_acc_prev_o);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int exp_d [3];
    exp_d = '{10, -10, 20};
    load_std();
    run_layer(-1, 0, 0, -1);
    n_checks++;
    if (n_res !== 3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 3", n_res);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_data[i] !== 16'(exp_d[i]) || r_idx[i] !== i) begin
        n_fail++;
        $display("FAIL basic_res%0d: got %0d idx %0d want %0d idx %0d",
                 i, $signed(r_data[i]), r_idx[i], exp_d[i], i);
      end
    end
    n_checks++;
    if (r_cyc[0] !== 6) begin
      n_fail++;
      $display("FAIL basic_first_valid: got cycle %0d want 6", r_cyc[0]);
    end
    n_checks++;
    if (r_cyc[1] !== 13 || r_cyc[2] !== 20) begin
      n_fail++;
      $display("FAIL basic_cadence: got %0d,%0d want 13,20",
               r_cyc[1], r_cyc[2]);
    end
    n_checks++;
    if (done_cyc !== 21 || n_done !== 1) begin
      n_fail++;
      $display("FAIL basic_done: got cycle %0d count %0d want 21 1",
               done_cyc, n_done);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got busy %b want 0", busy_o);
    end
`ifdef MAC_SEQ_ARGMAX_EN
    n_checks++;
    if (cls_seen !== 2 || cls_cyc !== done_cyc) begin
      n_fail++;
      $display("FAIL argmax_std: got class %0d at %0d want 2 at %0d",
               cls_seen, cls_cyc, done_cyc);
    end
`endif
  endtask

  task automatic test_stall();
    load_std();
    run_layer(1, 5, -10, -1);
    n_checks++;
    if (n_res !== 3 || r_data[1] !== 16'hFFF6 || r_data[2] !== 16'd20) begin
      n_fail++;
      $display("FAIL stall_res: got n=%0d %0d %0d want 3 -10 20",
               n_res, $signed(r_data[1]), $signed(r_data[2]));
    end
    n_checks++;
    if (r_cyc[1] !== 18 || r_cyc[2] !== 25 || done_cyc !== 26) begin
      n_fail++;
      $display("FAIL stall_timing: got %0d %0d %0d want 18 25 26",
               r_cyc[1], r_cyc[2], done_cyc);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      pix_mem[i]   = 8'd127;
      w_mem[i]     = 8'h80;
      w_mem[4 + i] = 8'd1;
      w_mem[8 + i] = 8'd0;
    end
    run_layer(-1, 0, 0, -1);
    n_checks++;
    if (r_data[0] !== 16'(-65024)) begin
      n_fail++;
      $display("FAIL wrap_n0: got %0d want %0d",
               $signed(r_data[0]), $signed(16'(-65024)));
    end
    n_checks++;
    if (r_data[1] !== 16'd508 || r_data[2] !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_n12: got %0d %0d want 508 0",
               $signed(r_data[1]), $signed(r_data[2]));
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    load_std();
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (busy_o !== 1'b1 || w_addr_o !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_pre: got busy %b waddr %0d want 1 5",
               busy_o, w_addr_o);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, done_o, res_valid_o} !== 3'b000 ||
        res_data_o !== 16'd0 || res_idx_o !== 2'd0 ||
        pix_addr_o !== 2'd0 || w_addr_o !== 4'd0 ||
        mac_pic_o !== 8'd0 || mac_w_o !== 8'd0 ||
        mac_acc_prev_o !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: got busy %b data %0d waddr %0d want 0",
               busy_o, res_data_o, w_addr_o);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_o || res_valid_o || busy_o) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL mid_quiet: got %0d active cycles want 0", bad);
    end
    run_layer(-1, 0, 0, -1);
    n_checks++;
    if (n_res !== 3 || r_data[0] !== 16'd10 ||
        r_data[1] !== 16'hFFF6 || r_data[2] !== 16'd20) begin
      n_fail++;
      $display("FAIL mid_rerun: got n=%0d %0d %0d %0d want 3 10 -10 20",
               n_res, $signed(r_data[0]), $signed(r_data[1]),
               $signed(r_data[2]));
    end
  endtask

  task automatic test_start_ignored();
    load_std();
    run_layer(-1, 0, 0, 2);
    n_checks++;
    if (n_res !== 3 || n_done !== 1 || done_cyc !== 21) begin
      n_fail++;
      $display("FAIL start_busy: got n=%0d done=%0d at %0d want 3 1 21",
               n_res, n_done, done_cyc);
    end
    n_checks++;
    if (r_data[2] !== 16'd20 || r_idx[2] !== 2) begin
      n_fail++;
      $display("FAIL start_busy_last: got %0d idx %0d want 20 idx 2",
               $signed(r_data[2]), r_idx[2]);
    end
  endtask

`ifdef MAC_SEQ_ARGMAX_EN
  task automatic test_argmax_tie();
    load_std();
    for (int i = 0; i < 4; i++) w_mem[8 + i] = 8'd1;
    run_layer(-1, 0, 0, -1);
    n_checks++;
    if (cls_seen !== 0 || cls_cyc !== done_cyc) begin
      n_fail++;
      $display("FAIL argmax_tie: got class %0d at %0d want 0 at %0d",
               cls_seen, cls_cyc, done_cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
`ifdef MAC_SEQ_ARGMAX_EN
    test_argmax_tie();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
